// File: rtl/tmr_sched_pkg.sv
// Shared definitions for the tick-driven timer scheduler: channel state encoding
// and default channel count / count width.
package tmr_sched_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  localparam int NCH_DEF = 4;
  localparam int CW_DEF  = 8;

endpackage

// File: rtl/tmr_sched_arb.sv
// Fixed-priority load arbiter: the lowest-index pending request wins and is
// acknowledged with a registered one-cycle ack.
module tmr_sched_arb
  import tmr_sched_pkg::*;
#(
  parameter int NCH = NCH_DEF
) (
  input  logic           ck,
  input  logic           resetn,
  input  logic [NCH-1:0] req,
  output logic [NCH-1:0] grant,
  output logic [NCH-1:0] ack
);

  // Handshake: req[i] is a level held by the requester until it sees ack[i]=1.
  // A channel whose ack is high this cycle is skipped, so one held request
  // yields exactly one grant; ack is one-hot or zero and lasts one cycle.
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!found && req[i] && !ack[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge ck) begin
    if (!resetn) ack <= '0;
    else         ack <= grant;
  end

endmodule

// File: rtl/tmr_sched.sv
// Multi-channel countdown timer scheduler with one shared decrementer steered
// by a scan pointer. Optional cancel input enabled by macro TMR_SCHED_CANCEL_EN.
module tmr_sched
  import tmr_sched_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CW  = CW_DEF
) (
  input  logic              ck,
  input  logic              resetn,
  input  logic              hz32,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*CW-1:0] ld_val,
`ifdef TMR_SCHED_CANCEL_EN
  input  logic [NCH-1:0]    cancel,
`endif
  output logic [NCH-1:0]    ack,
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    expire,
  output logic              ovr
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0] grant;
  logic [NCH-1:0] cancel_w;
  ch_state_e      state [NCH];
  logic [CW-1:0]  cnt   [NCH];
  logic [NCH-1:0] pend;
  logic [NCH-1:0] zload;
  logic [PW-1:0]  ptr;
  logic [CW-1:0]  dec_in;
  logic [CW-1:0]  dec_out;

`ifdef TMR_SCHED_CANCEL_EN
  assign cancel_w = cancel;
`else
  assign cancel_w = '0;
`endif

  tmr_sched_arb #(.NCH(NCH)) u_arb (
    .ck     (ck),
    .resetn (resetn),
    .req    (req),
    .grant  (grant),
    .ack    (ack)
  );

  // The only decrementer: it always works on the channel under the scan pointer.
  always_comb begin
    dec_in  = cnt[ptr];
    dec_out = dec_in - CW'(1);
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) busy[i] = (state[i] == ST_RUN);
  end

  always_ff @(posedge ck) begin
    if (!resetn) begin
      for (int i = 0; i < NCH; i++) begin
        state[i] <= ST_IDLE;
        cnt[i]   <= '0;
      end
      pend   <= '0;
      zload  <= '0;
      ptr    <= '0;
      expire <= '0;
      ovr    <= 1'b0;
    end else begin
      // A zero-value load reports expiry one cycle after its ack.
      expire <= zload;
      zload  <= '0;
      ptr    <= (ptr == PW'(NCH - 1)) ? '0 : ptr + PW'(1);
      for (int i = 0; i < NCH; i++) begin
        if (grant[i]) begin
          cnt[i]  <= ld_val[i*CW +: CW];
          pend[i] <= 1'b0;
          if (ld_val[i*CW +: CW] == '0) begin
            state[i] <= ST_IDLE;
            zload[i] <= 1'b1;
          end else begin
            state[i] <= ST_RUN;
          end
        end else if (cancel_w[i]) begin
          state[i] <= ST_IDLE;
          pend[i]  <= 1'b0;
        end else if (state[i] == ST_RUN) begin
          // A strobe landing on an unserviced tick is lost and flagged.
          if (hz32 && pend[i])  ovr     <= 1'b1;
          else if (hz32)        pend[i] <= 1'b1;
          if (pend[i] && (ptr == PW'(i))) begin
            cnt[i]  <= dec_out;
            pend[i] <= 1'b0;
            if (dec_in == CW'(1)) begin
              state[i]  <= ST_IDLE;
              expire[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/tmr_sched.md
TMR_SCHED -- requirements
Module: tmr_sched

Interface
REQ-001 Parameter NCH, default 4, number of timer channels (2..8).
REQ-002 Parameter CW, default 8, count width in tick units.
REQ-003 ck  input  1  system clock (32768 Hz); all logic on its rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 hz32  input  1  tick strobe, one ck cycle high per period.
REQ-006 req  input  NCH  per-channel load request, level, held until ack.
REQ-007 ld_val  input  NCH*CW  load values, channel i in bits [i*CW +: CW].
REQ-008 ack  output  NCH  one-cycle load grant, one-hot or zero.
REQ-009 busy  output  NCH  channel i running.
REQ-010 expire  output  NCH  one-cycle pulse when channel i reaches zero.
REQ-011 ovr  output  1  sticky tick-overrun flag.

Function
REQ-012 Each channel SHALL hold state IDLE or RUN, a CW-bit count and a pending-tick bit pend[i].
REQ-013 Load arbiter: each cycle, grant the lowest-index i with req[i]=1 and ack[i]=0 in the current cycle; assert ack[i] registered, for exactly one cycle.
REQ-014 On grant, the next cycle SHALL have cnt[i]=ld_val slice, pend[i]=0 and state RUN; this applies whether the channel was IDLE or RUN (restart).
REQ-015 A grant with ld_val=0 SHALL put the channel in IDLE and pulse expire[i] in the cycle after ack.
REQ-016 On hz32=1, pend[i] SHALL be set for every channel in RUN not being granted that cycle.
REQ-017 If hz32=1 while pend[i] is already 1, the tick SHALL be dropped and ovr set to 1.
REQ-018 A single shared decrementer SHALL be steered by a scan pointer ptr, which advances 0..NCH-1 and wraps to 0 every cycle.
REQ-019 When ptr=i, pend[i]=1 and there is no grant to i that cycle: cnt[i] decrements by 1 and pend[i] clears.
REQ-020 If that decrement takes cnt from 1 to 0: state becomes IDLE, busy[i]=0 and expire[i] pulses, all registered in the same following cycle.
REQ-021 A grant to channel i SHALL override any decrement of i in the same cycle.
REQ-022 busy[i] = (state RUN), registered.
REQ-023 Expiry latency from the hz32 strobe SHALL be at most NCH+1 cycles.

Reset
REQ-024 While resetn=0 at a ck edge, the following SHALL be cleared: all states to IDLE, cnt, pend, ptr, ack, busy, expire and ovr to 0.
REQ-025 A reset mid-count SHALL abandon every channel with no expire pulse.
REQ-026 ovr SHALL clear only on reset.

Configuration
REQ-027 With macro TMR_SCHED_CANCEL_EN defined, an input cancel[NCH] SHALL exist.
REQ-028 When cancel[i]=1, channel i SHALL go to IDLE with pend[i]=0 next cycle and no expire pulse.
REQ-029 Cancel SHALL lose to a same-cycle grant to i.
REQ-030 Without TMR_SCHED_CANCEL_EN the cancel port SHALL be absent, and channels leave RUN only by expiry or reset.

Structure
REQ-031 Shared package tmr_sched_pkg SHALL hold the state encoding (IDLE=0, RUN=1) and the default constants NCH=4 and CW=8.
REQ-032 One sub-module, tmr_sched_arb, SHALL implement the fixed-priority request/ack grant.
REQ-033 The scan/decrement logic SHALL stay in tmr_sched.

Verification
REQ-034 Scenario 1: req[1] with ld_val=3, then hz32 every 1024 cycles -> ack[1] for 1 cycle; busy[1]=1; expire[1] pulses within 5 cycles of the third strobe; busy[1]=0 afterwards.
REQ-035 Scenario 2: req[0] and req[2] raised in the same cycle -> ack[0] first, ack[2] in a later cycle, never both in one cycle.
REQ-036 Scenario 3: req[3] with ld_val=0 -> expire[3] in the cycle after ack[3], busy[3] stays 0.
REQ-037 Scenario 4: ch2 running with cnt=5; after 2 ticks, reload with 5 -> expire only 5 ticks after the reload; a reload in the cycle ptr=2 with pend set discards that tick.
REQ-038 Scenario 5: two hz32 strobes 2 cycles apart with ch3 running -> ovr=1, only one decrement, ovr remains 1 until resetn=0.
REQ-039 Scenario 6: resetn=0 for one cycle while 4 channels run -> all outputs 0 next cycle, no expire pulses; with TMR_SCHED_CANCEL_EN, cancel[1] on a running ch1 -> busy[1]=0 next cycle, no expire[1].
